// File: rtl/updown_ssd_pkg.sv
// Shared types and 7-segment glyph constants for the up/down counter display.
// Segment order is {A,B,C,D,E,F,G}: bit 6 = A ... bit 0 = G, active-high.
package updown_ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h7E;
    localparam seg_t SEG_1     = 7'h30;
    localparam seg_t SEG_2     = 7'h6D;
    localparam seg_t SEG_3     = 7'h79;
    localparam seg_t SEG_4     = 7'h33;
    localparam seg_t SEG_5     = 7'h5B;
    localparam seg_t SEG_6     = 7'h5F;
    localparam seg_t SEG_7     = 7'h70;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h7B;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h1F;  // lowercase b
    localparam seg_t SEG_C     = 7'h4E;
    localparam seg_t SEG_D     = 7'h3D;  // lowercase d
    localparam seg_t SEG_E     = 7'h4F;
    localparam seg_t SEG_F     = 7'h47;
    localparam seg_t SEG_BLANK = 7'h00;

    // Hex nibble to active-high segment pattern.
    function automatic seg_t seg_encode(input logic [3:0] nibble);
        seg_t s;
        case (nibble)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            4'hF:    s = SEG_F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, first tick DIV cycles after reset.
module tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Wrapping divide counter; tick is decoded from its terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/updown_ssd_mux.sv
// N-digit up/down counter with enable and synchronous load, driving a
// time-multiplexed 7-segment display.
// Build option: define UPDOWN_SSD_BCD_EN for decimal (BCD) counting with load clamping;
// otherwise the counter is plain binary with a hex display.
module updown_ssd_mux
    import updown_ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned COUNT_HZ       = 1,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   sel
);

    localparam int unsigned W        = 4 * NUM_DIGITS;
    localparam int unsigned CNT_DIV  = CLK_HZ / COUNT_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic INV = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_INV = {NUM_DIGITS{INV}};
    localparam seg_t                  SEG_INV = {7{INV}};

    logic             cnt_tick;
    logic             scan_tick;
    logic [W-1:0]     count_nx;
    logic             at_bound;
    logic [W-1:0]     load_fix;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       nibble;
    logic [NUM_DIGITS-1:0] sel_raw;

    tick_gen #(
        .DIV (CNT_DIV)
    ) u_cnt_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (cnt_tick)
    );

    tick_gen #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (scan_tick)
    );

`ifdef UPDOWN_SSD_BCD_EN
    logic carry;

    // Digit-wise BCD step; carry/borrow out of the top digit marks a wrap.
    always_comb begin
        count_nx = count;
        carry    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (dir) begin
                    if (count[4*i+:4] >= 4'd9) begin
                        count_nx[4*i+:4] = 4'd0;
                    end else begin
                        count_nx[4*i+:4] = count[4*i+:4] + 4'd1;
                        carry            = 1'b0;
                    end
                end else begin
                    if (count[4*i+:4] == 4'd0) begin
                        count_nx[4*i+:4] = 4'd9;
                    end else begin
                        count_nx[4*i+:4] = count[4*i+:4] - 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
        end
        at_bound = carry;
    end

    // Non-decimal nibbles of the load value saturate to 9.
    always_comb begin
        load_fix = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i+:4] > 4'd9) begin
                load_fix[4*i+:4] = 4'd9;
            end
        end
    end
`else
    // Binary step; wrap when leaving all-ones upward or zero downward.
    always_comb begin
        count_nx = dir ? (count + W'(1)) : (count - W'(1));
        at_bound = dir ? (count == {W{1'b1}}) : (count == '0);
        load_fix = load_val;
    end
`endif

    // Counter: load beats an enabled tick, which beats hold; wrap only on an enabled tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_fix;
            wrap  <= 1'b0;
        end else if (cnt_tick && en) begin
            count <= count_nx;
            wrap  <= at_bound;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // Scan index steps through the digits on each scan tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (scan_tick) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Digit select and the nibble it shows, both from the current index.
    always_comb begin
        nibble  = 4'd0;
        sel_raw = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble     = count[4*i+:4];
                sel_raw[i] = 1'b1;
            end
        end
    end

    // sel and seg registered together so the pins never show a mismatched pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= NUM_DIGITS'(1) ^ SEL_INV;
            seg <= SEG_0 ^ SEG_INV;
        end else begin
            sel <= sel_raw ^ SEL_INV;
            seg <= seg_encode(nibble) ^ SEG_INV;
        end
    end

endmodule
